// File: rtl/reg_serializer.sv
// Parallel-to-serial shifter with a one-word skid buffer so a producer can
// queue the next word while the current one drains, giving gap-free output.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | nothing shifting; outputs quiet, waiting for a word
//   SHIFT | shift register presenting bit cnt_q; hold buffer may be queued
module reg_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             xfer;
  logic             last_xfer;
  logic [WIDTH-1:0] shifted;

  // load_ready is gated by rst so it is low during reset independent of flops
  assign load_ready = rst && !hold_full_q;
  assign ser_valid  = (state_q == SHIFT);
  assign ser_bit    = ser_valid && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign ser_first  = ser_valid && (cnt_q == '0);
  assign ser_last   = ser_valid && (cnt_q == CNT_LAST);
  assign busy       = ser_valid || hold_full_q;

  assign accept    = load_valid && load_ready;
  assign xfer      = ser_valid && ser_ready;
  assign last_xfer = xfer && (cnt_q == CNT_LAST);

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (last_xfer) begin
          cnt_d = '0;
          // Hold buffer has priority; load_ready is low whenever it is full
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_d = load_data;
          end else begin
            shift_d = shifted;
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift out the MSB first and 0 = shift out the LSB first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_valid, input, 1 bit: the producer offers load_data.
REQ-006 SHALL have port load_ready, output, 1 bit: the block can accept a word.
REQ-007 SHALL have port load_data, input, WIDTH bits: the parallel word to serialize.
REQ-008 SHALL have port ser_valid, output, 1 bit: ser_bit, ser_first and ser_last are valid.
REQ-009 SHALL have port ser_ready, input, 1 bit: the consumer accepts the current bit.
REQ-010 SHALL have port ser_bit, output, 1 bit: the current serial data bit.
REQ-011 SHALL have port ser_first, output, 1 bit: the current bit is bit 0 of the word.
REQ-012 SHALL have port ser_last, output, 1 bit: the current bit is bit WIDTH-1 of the word.
REQ-013 SHALL have port busy, output, 1 bit: a word is shifting or held.

Function
REQ-014 SHALL contain a shift register, a bit counter of clog2(WIDTH) bits, a one-word hold buffer with a hold_full flag, and a two-state FSM with states IDLE and SHIFT.
REQ-015 SHALL define load acceptance as load_valid && load_ready sampled on the rising clk edge.
REQ-016 SHALL drive load_ready = !hold_full while rst is high, and 0 while rst is low.
REQ-017 IDLE: on acceptance, SHALL load load_data into the shift register, clear the counter to 0 and go to SHIFT; SHALL assert the first bit the cycle after acceptance (latency 1).
REQ-018 SHIFT: SHALL drive ser_valid = 1; ser_bit = shift register MSB if MSB_FIRST, else its LSB; ser_first = (counter == 0); ser_last = (counter == WIDTH-1).
REQ-019 SHALL count a bit transfer as ser_valid && ser_ready on a rising edge; on a transfer SHALL shift by one toward the output end and increment the counter.
REQ-020 While ser_valid && !ser_ready, SHALL hold ser_bit, ser_first and ser_last stable.
REQ-021 On acceptance in SHIFT without a last-bit transfer in the same cycle, SHALL write load_data into the hold buffer and set hold_full.
REQ-022 On the last-bit transfer with hold_full set, SHALL move the hold buffer into the shift register, clear hold_full, clear the counter and remain in SHIFT (no bubble).
REQ-023 On the last-bit transfer with hold_full clear and a same-cycle acceptance, SHALL load load_data straight into the shift register, clear the counter and remain in SHIFT.
REQ-024 On the last-bit transfer with hold_full clear and no acceptance, SHALL return to IDLE.
REQ-025 In IDLE, SHALL drive ser_valid, ser_bit, ser_first and ser_last to 0.
REQ-026 SHALL drive busy = (state == SHIFT) || hold_full.
REQ-027 SHALL sustain a throughput of one bit per clock when ser_ready is held high and the producer keeps the hold buffer filled.

Reset
REQ-028 While rst is low, SHALL asynchronously force: state IDLE; counter 0; shift register 0; hold buffer 0; hold_full 0.
REQ-029 While rst is low, SHALL drive ser_valid, ser_bit, ser_first, ser_last, busy and load_ready to 0.
REQ-030 Reset asserted mid-word SHALL discard the partial word and any held word; after release, no residual bits SHALL appear.
REQ-031 SHALL raise load_ready to 1 in the first cycle after rst goes high.

Verification
REQ-032 Default parameters, ser_ready=1, accept 0xA5 in cycle N -> ser_bit 1,0,1,0,0,1,0,1 in cycles N+1..N+8; ser_first in N+1 only; ser_last in N+8 only; IDLE and busy=0 in N+9.
REQ-033 Back-to-back 0xA5 then 0x3C, ser_ready=1 -> 16 contiguous valid bits with no bubble; load_ready=0 from the cycle after 0x3C is held until the last bit of 0xA5 transfers.
REQ-034 0xA5 with ser_ready toggling 1,0,0,1,... -> outputs stable during stalls; exactly 8 transfers; sequence identical to REQ-032.
REQ-035 MSB_FIRST=0, load 0x01 -> first bit 1 (ser_first=1), then seven 0s, ser_last on the 8th bit.
REQ-036 Hold buffer full and load_valid=1 with 0xFF -> load_ready=0 and 0xFF is never serialized unless re-offered after load_ready returns to 1.
REQ-037 rst driven low after 3 bits of 0xA5 with 0x3C held -> ser_valid=0 and busy=0 immediately, without waiting for a clock edge; after release load_ready=1 and ser_valid stays 0 until a new word is accepted.
